sysid_boot_checker: RTL and testbench

- Avalon-MM master that sequences reads of the system-ID slave (word 0 = system ID, word 1 = build timestamp) after reset, and again on request.
- Compares both words against expected values and publishes sticky match/mismatch/timeout status.
- Sits between the sysid control slave and the board-level status LEDs and the boot-hold logic, so software or hardware can refuse to run on a mismatched bitstream.

---
 rtl/sysid_boot_checker_if.sv | 21 ++
 rtl/sysid_boot_checker.sv | 187 ++++++++++++++++++
 tb/tb_sysid_boot_checker.sv | 320 ++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/sysid_boot_checker_if.sv
// Avalon-MM read-only link between the boot checker (master) and the sysid slave.
interface sysid_boot_checker_if;
    logic        avm_address;
    logic        avm_read;
    logic        avm_waitrequest;
    logic [31:0] avm_readdata;

    modport master (
        output avm_address,
        output avm_read,
        input  avm_waitrequest,
        input  avm_readdata
    );

    modport slave (
        input  avm_address,
        input  avm_read,
        output avm_waitrequest,
        output avm_readdata
    );
endinterface

// File: rtl/sysid_boot_checker.sv
// Reads sysid word 0 (ID) and word 1 (timestamp) after reset or on request and
// publishes sticky match / mismatch / stall-timeout status for boot-hold logic.
module sysid_boot_checker #(
    parameter logic [31:0] EXPECTED_ID        = 32'h0000_0000,
    parameter logic [31:0] EXPECTED_TIMESTAMP = 32'd1435750158,
    parameter int unsigned READ_LATENCY       = 0,
    parameter int unsigned TIMEOUT_CYCLES     = 255,
    parameter bit          START_ON_RESET     = 1'b1
) (
    input  logic                 clock,
    input  logic                 reset_n,
    input  logic                 start,
    sysid_boot_checker_if.master bus,
    output logic                 busy,
    output logic                 done,
    output logic                 match,
    output logic                 id_ok,
    output logic                 ts_ok,
    output logic                 timeout,
    output logic [31:0]          id_value,
    output logic [31:0]          ts_value
);

    localparam int unsigned STALL_W = 16;
    localparam int unsigned LAT_W   = 3;
    localparam bit          ZERO_LAT = (READ_LATENCY == 32'd0);
    localparam logic [LAT_W-1:0]   LAT_LAST   = LAT_W'(ZERO_LAT ? 32'd0 : READ_LATENCY - 32'd1);
    localparam logic [STALL_W-1:0] STALL_LAST = STALL_W'(TIMEOUT_CYCLES - 32'd1);

    localparam logic [2:0] S_IDLE    = 3'd0;
    localparam logic [2:0] S_CMD_ID  = 3'd1;
    localparam logic [2:0] S_WAIT_ID = 3'd2;
    localparam logic [2:0] S_CMD_TS  = 3'd3;
    localparam logic [2:0] S_WAIT_TS = 3'd4;
    localparam logic [2:0] S_DONE    = 3'd5;

    logic [2:0]         state, state_nxt;
    logic               pending, pending_nxt;
    logic [STALL_W-1:0] stall_cnt, stall_nxt;
    logic [LAT_W-1:0]   lat_cnt, lat_nxt;
    logic               rd_q, rd_nxt;
    logic               addr_q, addr_nxt;
    logic               busy_nxt, done_nxt, match_nxt, id_ok_nxt, ts_ok_nxt, timeout_nxt;
    logic [31:0]        id_value_nxt, ts_value_nxt;
    logic               capture;
    logic               word_ts;

    assign bus.avm_read    = rd_q;
    assign bus.avm_address = addr_q;

    // State and registered outputs
    always_ff @(posedge clock) begin
        if (!reset_n) begin
            state     <= S_IDLE;
            pending   <= START_ON_RESET;
            stall_cnt <= '0;
            lat_cnt   <= '0;
            rd_q      <= 1'b0;
            addr_q    <= 1'b0;
            busy      <= 1'b0;
            done      <= 1'b0;
            match     <= 1'b0;
            id_ok     <= 1'b0;
            ts_ok     <= 1'b0;
            timeout   <= 1'b0;
            id_value  <= '0;
            ts_value  <= '0;
        end else begin
            state     <= state_nxt;
            pending   <= pending_nxt;
            stall_cnt <= stall_nxt;
            lat_cnt   <= lat_nxt;
            rd_q      <= rd_nxt;
            addr_q    <= addr_nxt;
            busy      <= busy_nxt;
            done      <= done_nxt;
            match     <= match_nxt;
            id_ok     <= id_ok_nxt;
            ts_ok     <= ts_ok_nxt;
            timeout   <= timeout_nxt;
            id_value  <= id_value_nxt;
            ts_value  <= ts_value_nxt;
        end
    end

    // Next state and next output values
    always_comb begin
        state_nxt    = state;
        pending_nxt  = pending;
        stall_nxt    = stall_cnt;
        lat_nxt      = lat_cnt;
        rd_nxt       = rd_q;
        addr_nxt     = addr_q;
        busy_nxt     = busy;
        done_nxt     = done;
        match_nxt    = match;
        id_ok_nxt    = id_ok;
        ts_ok_nxt    = ts_ok;
        timeout_nxt  = timeout;
        id_value_nxt = id_value;
        ts_value_nxt = ts_value;
        capture      = 1'b0;
        word_ts      = (state == S_CMD_TS) || (state == S_WAIT_TS);

        case (state)
            S_IDLE: begin
                if (start || pending) begin
                    state_nxt    = S_CMD_ID;
                    pending_nxt  = 1'b0;
                    stall_nxt    = '0;
                    lat_nxt      = '0;
                    rd_nxt       = 1'b1;
                    addr_nxt     = 1'b0;
                    busy_nxt     = 1'b1;
                    done_nxt     = 1'b0;
                    match_nxt    = 1'b0;
                    id_ok_nxt    = 1'b0;
                    ts_ok_nxt    = 1'b0;
                    timeout_nxt  = 1'b0;
                    id_value_nxt = '0;
                    ts_value_nxt = '0;
                end
            end
            S_CMD_ID, S_CMD_TS: begin
                if (!bus.avm_waitrequest) begin
                    stall_nxt = '0;
                    if (ZERO_LAT) begin
                        capture = 1'b1;
                    end else begin
                        state_nxt = word_ts ? S_WAIT_TS : S_WAIT_ID;
                        rd_nxt    = 1'b0;
                        lat_nxt   = '0;
                    end
                end else if (stall_cnt == STALL_LAST) begin
                    // Slave never answered: give up with whatever was captured so far
                    state_nxt   = S_IDLE;
                    stall_nxt   = '0;
                    rd_nxt      = 1'b0;
                    busy_nxt    = 1'b0;
                    done_nxt    = 1'b1;
                    timeout_nxt = 1'b1;
                    match_nxt   = 1'b0;
                    id_ok_nxt   = 1'b0;
                    ts_ok_nxt   = 1'b0;
                end else begin
                    stall_nxt = stall_cnt + STALL_W'(1);
                end
            end
            S_WAIT_ID, S_WAIT_TS: begin
                if (lat_cnt == LAT_LAST) begin
                    capture = 1'b1;
                end else begin
                    lat_nxt = lat_cnt + LAT_W'(1);
                end
            end
            S_DONE: begin
                state_nxt = S_IDLE;
                busy_nxt  = 1'b0;
                done_nxt  = 1'b1;
                id_ok_nxt = (id_value == EXPECTED_ID);
                ts_ok_nxt = (ts_value == EXPECTED_TIMESTAMP);
                match_nxt = (id_value == EXPECTED_ID) && (ts_value == EXPECTED_TIMESTAMP);
            end
            default: begin
                state_nxt = S_IDLE;
                rd_nxt    = 1'b0;
                busy_nxt  = 1'b0;
            end
        endcase

        // Shared capture path for both latency modes
        if (capture) begin
            lat_nxt = '0;
            if (word_ts) begin
                ts_value_nxt = bus.avm_readdata;
                state_nxt    = S_DONE;
                rd_nxt       = 1'b0;
            end else begin
                id_value_nxt = bus.avm_readdata;
                state_nxt    = S_CMD_TS;
                rd_nxt       = 1'b1;
                addr_nxt     = 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_sysid_boot_checker.sv
// Bench: two checkers (zero latency; latency 2 with short timeout) against a
// scripted sysid slave, with a timeline model checked every cycle.
module tb_sysid_boot_checker;

    localparam logic [31:0] TS_GOOD = 32'd1435750158;
    localparam logic [31:0] ID1     = 32'h1234_5678;
    localparam logic [31:0] JUNK    = 32'hDEAD_BEEF;
    localparam int          STUCK   = 1000;

    typedef struct packed {
        logic        busy;
        logic        done;
        logic        match;
        logic        id_ok;
        logic        ts_ok;
        logic        timeout;
        logic        rd;
        logic        adr;
        logic [31:0] idv;
        logic [31:0] tsv;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [1:0]  start = 2'b00;
    logic [1:0]  busy, done, match, id_ok, ts_ok, timeout;
    logic [31:0] id_value [2];
    logic [31:0] ts_value [2];

    logic [1:0]  rd, adr, wr;
    logic [31:0] rdata [2];

    logic [31:0] mem_id [2] = '{32'h0, ID1};
    logic [31:0] mem_ts [2] = '{TS_GOOD, TS_GOOD};
    int          stall_n [2] = '{0, 0};
    int          scnt [2] = '{0, 0};
    int          dcnt [2] = '{0, 0};
    logic [1:0]  daddr = 2'b00;
    int          nreads [2] = '{0, 0};

    int          cyc = 0;
    bit          armed = 1'b0;
    bit          has_chk [2] = '{1'b0, 1'b0};
    bit          pend [2] = '{1'b0, 1'b0};
    int          t_start [2] = '{0, 0};
    int          t_end [2] = '{0, 0};
    int          s_rec [2] = '{0, 0};
    logic [31:0] id_rec [2];
    logic [31:0] ts_rec [2];

    int          n_checks = 0;
    int          n_pass = 0;
    exp_t        xe;

    always #5 clk = ~clk;

    sysid_boot_checker_if bus0 ();
    sysid_boot_checker_if bus1 ();

    assign rd[0] = bus0.avm_read;
    assign adr[0] = bus0.avm_address;
    assign bus0.avm_waitrequest = wr[0];
    assign bus0.avm_readdata = rdata[0];
    assign rd[1] = bus1.avm_read;
    assign adr[1] = bus1.avm_address;
    assign bus1.avm_waitrequest = wr[1];
    assign bus1.avm_readdata = rdata[1];

    sysid_boot_checker u0 (
        .clock(clk), .reset_n(rst_n), .start(start[0]), .bus(bus0),
        .busy(busy[0]), .done(done[0]), .match(match[0]), .id_ok(id_ok[0]),
        .ts_ok(ts_ok[0]), .timeout(timeout[0]), .id_value(id_value[0]), .ts_value(ts_value[0])
    );

    sysid_boot_checker #(
        .EXPECTED_ID(ID1), .READ_LATENCY(2), .TIMEOUT_CYCLES(8)
    ) u1 (
        .clock(clk), .reset_n(rst_n), .start(start[1]), .bus(bus1),
        .busy(busy[1]), .done(done[1]), .match(match[1]), .id_ok(id_ok[1]),
        .ts_ok(ts_ok[1]), .timeout(timeout[1]), .id_value(id_value[1]), .ts_value(ts_value[1])
    );

    function automatic int rl_of(input int d);
        return (d == 0) ? 0 : 2;
    endfunction

    function automatic int to_of(input int d);
        return (d == 0) ? 255 : 8;
    endfunction

    function automatic logic [31:0] exp_id(input int d);
        return (d == 0) ? 32'h0 : ID1;
    endfunction

    // Edge at which a check started on edge e0 with s stall cycles per command finishes
    function automatic int end_of(input int d, input int e0, input int s);
        if (s >= to_of(d)) return e0 + to_of(d);
        return e0 + 2 * (s + 1 + rl_of(d)) + 1;
    endfunction

    // Expected outputs after edge e, from the timeline of the most recent check
    function automatic exp_t model(input int d, input int e);
        exp_t x;
        int a0, c0, a1, c1;
        bit to;
        x = '0;
        if (!has_chk[d]) return x;
        a0 = t_start[d] + s_rec[d] + 1;
        c0 = a0 + rl_of(d);
        a1 = c0 + s_rec[d] + 1;
        c1 = a1 + rl_of(d);
        to = (s_rec[d] >= to_of(d));
        x.idv = (e >= c0) ? id_rec[d] : 32'h0;
        x.tsv = (e >= c1) ? ts_rec[d] : 32'h0;
        if (e < t_end[d]) begin
            x.busy = 1'b1;
            x.rd   = (e < a0) || (e >= c0 && e < a1);
            x.adr  = x.rd && (e >= c0);
        end else begin
            x.done    = 1'b1;
            x.timeout = to;
            x.id_ok   = !to && (id_rec[d] == exp_id(d));
            x.ts_ok   = !to && (ts_rec[d] == TS_GOOD);
            x.match   = x.id_ok && x.ts_ok;
        end
        return x;
    endfunction

    task automatic chk(input string name, input int d, input logic [31:0] act, input logic [31:0] want);
        n_checks++;
        if (act === want) n_pass++;
        else $display("FAIL %s dut%0d cyc %0d: got %0h expected %0h", name, d, cyc, act, want);
    endtask

    // Scripted sysid slave: stall_n wait cycles per command, data valid rl cycles after accept
    always_comb begin
        for (int d = 0; d < 2; d++) begin
            wr[d] = (stall_n[d] == STUCK) || (rd[d] && (scnt[d] < stall_n[d]));
            rdata[d] = JUNK;
            if (rl_of(d) == 0) begin
                if (rd[d] && !wr[d]) rdata[d] = adr[d] ? mem_ts[d] : mem_id[d];
            end else if (dcnt[d] == 1) begin
                rdata[d] = daddr[d] ? mem_ts[d] : mem_id[d];
            end
        end
    end

    always @(posedge clk) begin
        for (int d = 0; d < 2; d++) begin
            if (!rst_n) begin
                scnt[d] <= 0;
                dcnt[d] <= 0;
            end else begin
                if (dcnt[d] != 0) dcnt[d] <= dcnt[d] - 1;
                if (rd[d] && !wr[d]) begin
                    nreads[d] <= nreads[d] + 1;
                    scnt[d] <= 0;
                    if (rl_of(d) != 0) begin
                        dcnt[d] <= rl_of(d);
                        daddr[d] <= adr[d];
                    end
                end else if (rd[d]) begin
                    scnt[d] <= scnt[d] + 1;
                end else begin
                    scnt[d] <= 0;
                end
            end
        end
    end

    // Model: decide which edges begin a check
    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (!rst_n) armed <= 1'b1;
        for (int d = 0; d < 2; d++) begin
            if (!rst_n) begin
                has_chk[d] <= 1'b0;
                pend[d] <= 1'b1;
            end else if ((start[d] || pend[d]) && (!has_chk[d] || (cyc + 1 > t_end[d]))) begin
                has_chk[d] <= 1'b1;
                pend[d]    <= 1'b0;
                t_start[d] <= cyc + 1;
                t_end[d]   <= end_of(d, cyc + 1, stall_n[d]);
                s_rec[d]   <= stall_n[d];
                id_rec[d]  <= mem_id[d];
                ts_rec[d]  <= mem_ts[d];
            end
        end
    end

    always @(negedge clk) begin
        if (armed) begin
            for (int d = 0; d < 2; d++) begin
                xe = model(d, cyc);
                chk("busy", d, 32'(busy[d]), 32'(xe.busy));
                chk("done", d, 32'(done[d]), 32'(xe.done));
                chk("match", d, 32'(match[d]), 32'(xe.match));
                chk("id_ok", d, 32'(id_ok[d]), 32'(xe.id_ok));
                chk("ts_ok", d, 32'(ts_ok[d]), 32'(xe.ts_ok));
                chk("timeout", d, 32'(timeout[d]), 32'(xe.timeout));
                chk("avm_read", d, 32'(rd[d]), 32'(xe.rd));
                chk("avm_address", d, 32'(rd[d] & adr[d]), 32'(xe.adr));
                chk("id_value", d, id_value[d], xe.idv);
                chk("ts_value", d, ts_value[d], xe.tsv);
            end
        end
    end

    task automatic pulse(input int d);
        @(negedge clk);
        start[d] = 1'b1;
        @(negedge clk);
        start[d] = 1'b0;
    endtask

    task automatic wait_done(input int d, input int lim);
        int k;
        k = 0;
        while (!(done[d] === 1'b1 && busy[d] === 1'b0) && k < lim) begin
            @(negedge clk);
            k++;
        end
        chk("wait_done", d, 32'(k < lim), 32'd1);
    endtask

    initial begin
        int n0;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;

        // Power-up check: default slave contents, zero wait
        repeat (3) @(negedge clk);
        chk("t1_done_early", 0, 32'(done[0]), 32'd0);
        @(negedge clk);
        chk("t1_done", 0, 32'(done[0]), 32'd1);
        chk("t1_match", 0, 32'(match[0]), 32'd1);
        chk("t1_id_value", 0, id_value[0], 32'h0);
        chk("t1_ts_value", 0, ts_value[0], 32'd1435750158);
        chk("t1_reads", 0, 32'(nreads[0]), 32'd2);
        wait_done(1, 40);
        chk("t1_match", 1, 32'(match[1]), 32'd1);
        chk("t1_id_value", 1, id_value[1], 32'h1234_5678);

        // Timestamp off by one
        mem_ts[0] = TS_GOOD + 32'd1;
        pulse(0);
        wait_done(0, 20);
        chk("t2_id_ok", 0, 32'(id_ok[0]), 32'd1);
        chk("t2_ts_ok", 0, 32'(ts_ok[0]), 32'd0);
        chk("t2_match", 0, 32'(match[0]), 32'd0);
        chk("t2_ts_value", 0, ts_value[0], 32'd1435750159);
        mem_ts[0] = TS_GOOD;

        // Three stall cycles per command, latency 2
        stall_n[1] = 3;
        pulse(1);
        repeat (12) @(negedge clk);
        chk("t3_done_early", 1, 32'(done[1]), 32'd0);
        @(negedge clk);
        chk("t3_done", 1, 32'(done[1]), 32'd1);
        chk("t3_match", 1, 32'(match[1]), 32'd1);

        // Stuck waitrequest, then recovery
        stall_n[1] = STUCK;
        pulse(1);
        repeat (7) @(negedge clk);
        chk("t4_read_held", 1, 32'(rd[1]), 32'd1);
        @(negedge clk);
        chk("t4_read_drop", 1, 32'(rd[1]), 32'd0);
        chk("t4_timeout", 1, 32'(timeout[1]), 32'd1);
        chk("t4_done", 1, 32'(done[1]), 32'd1);
        chk("t4_busy", 1, 32'(busy[1]), 32'd0);
        stall_n[1] = 0;
        pulse(1);
        wait_done(1, 40);
        chk("t4_rematch", 1, 32'(match[1]), 32'd1);
        chk("t4_timeout_clr", 1, 32'(timeout[1]), 32'd0);

        // start held through busy and the DONE cycle
        n0 = nreads[0];
        @(negedge clk);
        start[0] = 1'b1;
        repeat (4) @(negedge clk);
        start[0] = 1'b0;
        chk("t5_done", 0, 32'(done[0]), 32'd1);
        repeat (4) @(negedge clk);
        chk("t5_reads", 0, 32'(nreads[0]), 32'(n0 + 2));
        pulse(0);
        chk("t5_done_clr", 0, 32'(done[0]), 32'd0);
        wait_done(0, 20);
        chk("t5_reads2", 0, 32'(nreads[0]), 32'(n0 + 4));

        // Reset while fetching the timestamp
        stall_n[1] = 3;
        pulse(1);
        repeat (7) @(negedge clk);
        chk("t6_in_cmd_ts", 1, 32'(rd[1] & adr[1]), 32'd1);
        rst_n = 1'b0;
        @(negedge clk);
        chk("t6_read", 1, 32'(rd[1]), 32'd0);
        chk("t6_busy", 1, 32'(busy[1]), 32'd0);
        chk("t6_id_value", 1, id_value[1], 32'h0);
        n0 = nreads[1];
        rst_n = 1'b1;
        wait_done(1, 60);
        chk("t6_match", 1, 32'(match[1]), 32'd1);
        chk("t6_reads", 1, 32'(nreads[1]), 32'(n0 + 2));

        repeat (3) @(negedge clk);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: bench did not finish, got timeout expected completion");
        $fatal(1, "watchdog");
    end

endmodule
